// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit and the mult/div engine.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             mult_overflow;

  modport master (
    output start, op, opa, opb, abort,
    input  busy, done, hi, lo, div_by_zero, mult_overflow
  );

  modport slave (
    input  start, op, opa, opb, abort,
    output busy, done, hi, lo, div_by_zero, mult_overflow
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 step on unsigned magnitudes.
// Multiply: {hi,lo} holds {partial product, remaining multiplier bits}; add-or-pass then shift right.
// Divide:   {hi,lo} holds {partial remainder, remaining dividend bits}; trial subtract, restore on borrow,
//           quotient bit shifts into lo from the right.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Single shift-add or shift-subtract step
  always_comb begin
    sum     = {1'b0, hi_in} + {1'b0, divisor};
    shifted = {hi_in, lo_in[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor};
    // when the trial subtract fits, the true difference is below divisor so the low bits suffice
    diff    = shifted[WIDTH-1:0] - divisor;
    hi_out  = hi_in;
    lo_out  = lo_in;
    if (is_div) begin
      hi_out = fits ? diff : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], fits};
    end else if (lo_in[0]) begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else begin
      hi_out = {1'b0, hi_in[WIDTH-1:1]};
      lo_out = {hi_in[0], lo_in[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine for the HI/LO path.
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   PREP  | sign/magnitude split, zero-divisor shortcut, counter load
//   ITER  | UNROLL steps per cycle for WIDTH/UNROLL cycles
//   FIX   | apply result signs, compute flags
//   DONE  | one-cycle done pulse; hi/lo/flags already updated
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int UNROLL    = 1,
  parameter int SIGNED_EN = 1
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N) + 1;

  state_e           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic             neg_main, neg_rem;
  logic             busy_q, done_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_div, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;
  logic             fix_ovf;

  // With SIGNED_EN=0 op[0] is ignored and every op behaves as its unsigned form
  assign is_div    = op_r[1];
  assign signed_op = (SIGNED_EN != 0) && !op_r[0];
  assign a_neg     = signed_op && a_r[WIDTH-1];
  assign b_neg     = signed_op && b_r[WIDTH-1];
  assign a_mag     = a_neg ? -a_r : a_r;
  assign b_mag     = b_neg ? -b_r : b_r;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [WIDTH-1:0] hi_in, lo_in, hi_o, lo_o;
    if (g == 0) begin : g_first
      assign hi_in = acc_hi;
      assign lo_in = acc_lo;
    end else begin : g_next
      assign hi_in = g_step[g-1].hi_o;
      assign lo_in = g_step[g-1].lo_o;
    end
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .hi_in   (hi_in),
      .lo_in   (lo_in),
      .divisor (b_r),
      .hi_out  (hi_o),
      .lo_out  (lo_o)
    );
  end
  assign step_hi = g_step[UNROLL-1].hi_o;
  assign step_lo = g_step[UNROLL-1].lo_o;

  // Sign fix-up of the magnitude result and overflow detection
  always_comb begin
    prod    = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo     = neg_main ? -acc_lo : acc_lo;
    rem     = neg_rem  ? -acc_hi : acc_hi;
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_lo  = prod[WIDTH-1:0];
    fix_ovf = signed_op ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (prod[2*WIDTH-1:WIDTH] != '0);
    if (is_div) begin
      fix_hi  = rem;
      fix_lo  = quo;
      fix_ovf = 1'b0;
    end
  end

  // Sequencer with registered outputs; abort returns to IDLE without touching results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            op_r   <= bus.op;
            a_r    <= bus.opa;
            b_r    <= bus.opb;
            busy_q <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (is_div && (b_r == '0)) begin
            hi_q   <= a_r;
            lo_q   <= '1;
            dbz_q  <= 1'b1;
            ovf_q  <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            b_r      <= b_mag;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= CW'(N);
            state    <= ITER;
          end
        end
        ITER: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            dbz_q  <= 1'b0;
            ovf_q  <= fix_ovf;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.mult_overflow = ovf_q;
endmodule
